// File: rtl/ysyx_23060025_define.sv
// Shared encodings for the LSU: memory-op codes, FSM states and small
// decode helpers used by both the control path and the load aligner.
package ysyx_23060025_define;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    // Loads drive no strobes; the bus ignores wstrb when we=0.
    function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   return 4'b0001 << off;
            OP_SH:   return 4'b0011 << off;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060025_load_align.sv
// Picks the addressed byte/halfword out of a loaded word and extends it
// to the register width; lw and unknown ops pass the word through.
module ysyx_23060025_load_align
    import ysyx_23060025_define::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [3:0]          op_i,
    input  logic [1:0]          off_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    output logic [DATA_LEN-1:0] data_o
);

    logic [DATA_LEN-1:0] lane;

    assign lane = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = rdata_i;
        case (op_i)
            OP_LB:   data_o = {{(DATA_LEN-8){lane[7]}}, lane[7:0]};
            OP_LH:   data_o = {{(DATA_LEN-16){lane[15]}}, lane[15:0]};
            OP_LBU:  data_o = {{(DATA_LEN-8){1'b0}}, lane[7:0]};
            OP_LHU:  data_o = {{(DATA_LEN-16){1'b0}}, lane[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_23060025_lsu.sv
// Memory stage: accepts one instruction at a time, issues an aligned bus
// request for loads/stores and hands the result to writeback.
module ysyx_23060025_lsu
    import ysyx_23060025_define::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                es_to_ms_valid,
    output logic                ms_allowin_o,
    input  logic [3:0]          mem_op_i,
    input  logic [ADDR_LEN-1:0] alu_result_i,
    input  logic [DATA_LEN-1:0] store_data_i,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    output logic                ms_to_ws_valid,
    input  logic                ws_allowin_i,
    output logic                wd_o,
    output logic [4:0]          wreg_o,
    output logic [DATA_LEN-1:0] reg_wdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_req_we_o,
    output logic [ADDR_LEN-1:0] mem_req_addr_o,
    output logic [DATA_LEN-1:0] mem_req_wdata_o,
    output logic [3:0]          mem_req_wstrb_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_LEN-1:0] mem_rsp_rdata_i,
    output logic                misalign_o
);

    lsu_state_e          state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [1:0]          off_q, off_d;
    logic                wd_q, wd_d;
    logic [4:0]          wreg_q, wreg_d;
    logic [DATA_LEN-1:0] result_q, result_d;
    logic                misalign_q, misalign_d;
    logic                we_q, we_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] sdata_q, sdata_d;
    logic [3:0]          strb_q, strb_d;
    logic                accept;
    logic [DATA_LEN-1:0] load_data;

    ysyx_23060025_load_align #(
        .DATA_LEN (DATA_LEN)
    ) u_load_align (
        .op_i    (op_q),
        .off_i   (off_q),
        .rdata_i (mem_rsp_rdata_i),
        .data_o  (load_data)
    );

    assign ms_allowin_o    = (state_q == S_IDLE) || ((state_q == S_DONE) && ws_allowin_i);
    assign accept          = es_to_ms_valid && ms_allowin_o;
    assign ms_to_ws_valid  = (state_q == S_DONE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign wd_o            = wd_q;
    assign wreg_o          = wreg_q;
    assign reg_wdata_o     = result_q;
    assign misalign_o      = misalign_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = sdata_q;
    assign mem_req_wstrb_o = strb_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        result_d   = result_q;
        misalign_d = 1'b0;
        we_d       = we_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        strb_d     = strb_q;

        // Responses are only looked at in WAIT, so one coinciding with the
        // request handshake, or arriving after a reset, is dropped.
        case (state_q)
            S_REQ:   if (mem_req_ready_i) state_d = S_WAIT;
            S_WAIT:  if (mem_rsp_valid_i) begin
                         state_d  = S_DONE;
                         result_d = op_is_store(op_q) ? '0 : load_data;
                     end
            S_DONE:  if (ws_allowin_i) state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            wreg_d = wreg_i;
            if (!op_is_load(mem_op_i) && !op_is_store(mem_op_i)) begin
                state_d  = S_DONE;
                wd_d     = wd_i;
                result_d = DATA_LEN'(alu_result_i);
            end else if (op_misaligned(mem_op_i, alu_result_i[1:0])) begin
                state_d    = S_DONE;
                wd_d       = 1'b0;
                result_d   = '0;
                misalign_d = 1'b1;
            end else begin
                state_d = S_REQ;
                op_d    = mem_op_i;
                off_d   = alu_result_i[1:0];
                wd_d    = op_is_store(mem_op_i) ? 1'b0 : wd_i;
                we_d    = op_is_store(mem_op_i);
                addr_d  = {alu_result_i[ADDR_LEN-1:2], 2'b00};
                sdata_d = store_data_i << {alu_result_i[1:0], 3'b000};
                strb_d  = store_strb(mem_op_i, alu_result_i[1:0]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            off_q      <= '0;
            wd_q       <= 1'b0;
            wreg_q     <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sdata_q    <= '0;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            result_q   <= result_d;
            misalign_q <= misalign_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            strb_q     <= strb_d;
        end
    end

endmodule
